bit40_div: RTL and testbench

BIT40_DIV -- requirements
Module: bit40_div

---
 rtl/bit40_div.sv | 112 +++++++++++
 tb/tb_bit40_div.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit40_div.sv
// 40-bit by 8-bit unsigned restoring divider producing a 32-bit quotient and 8-bit remainder.
// One quotient bit per cycle; zero-divisor and quotient-overflow cases finish immediately.
module bit40_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [39:0] A,
    input  logic [7:0]  B,
    output logic [31:0] Q,
    output logic [7:0]  R,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [7:0]  r_rem;
    logic [31:0] r_shift;
    logic [7:0]  r_b;
    logic [31:0] r_q;
    logic [7:0]  r_r;
    logic        r_dz;
    logic        r_ovf;

    logic [8:0]  w_trial;
    logic        w_ge;
    logic [7:0]  w_diff;
    logic [7:0]  w_rem_next;
    logic [31:0] w_shift_next;

    // Trial value is below 2*B, so a successful subtraction always lands below 256.
    assign w_trial      = {r_rem, r_shift[31]};
    assign w_ge         = (w_trial >= {1'b0, r_b});
    assign w_diff       = w_trial[7:0] - r_b;
    assign w_rem_next   = w_ge ? w_diff : w_trial[7:0];
    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign w_shift_next = {r_shift[30:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_rem   <= 8'd0;
            r_shift <= 32'd0;
            r_b     <= 8'd0;
            r_q     <= 32'd0;
            r_r     <= 8'd0;
            r_dz    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_b <= B;
                        if (B == 8'd0) begin
                            r_dz    <= 1'b1;
                            r_ovf   <= 1'b0;
                            r_q     <= 32'hFFFF_FFFF;
                            r_r     <= 8'hFF;
                            r_state <= S_FIN;
                        end else if (A[39:32] >= B) begin
                            r_dz    <= 1'b0;
                            r_ovf   <= 1'b1;
                            r_q     <= 32'hFFFF_FFFF;
                            r_r     <= 8'hFF;
                            r_state <= S_FIN;
                        end else begin
                            r_rem   <= A[39:32];
                            r_shift <= A[31:0];
                            r_cnt   <= 5'd0;
                            r_dz    <= 1'b0;
                            r_ovf   <= 1'b0;
                            r_q     <= 32'd0;
                            r_r     <= 8'd0;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_rem   <= w_rem_next;
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_q     <= w_shift_next;
                        r_r     <= w_rem_next;
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Q        = r_q;
    assign R        = r_r;
    assign div_zero = r_dz;
    assign ovf      = r_ovf;
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_FIN);

endmodule

// File: tb/tb_bit40_div.sv
// Directed testbench for bit40_div: hand-computed quotients, error paths, latency,
// start filtering, back-to-back operation and asynchronous reset abort.
module tb_bit40_div;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [39:0] A;
    logic [7:0]  B;
    logic [31:0] Q;
    logic [7:0]  R;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        ovf;

    int checks;
    int errors;

    bit40_div dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (A),
        .B        (B),
        .Q        (Q),
        .R        (R),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch a request so that it is captured on the next rising edge; returns #1 after it.
    task automatic capture(input logic [39:0] a, input logic [7:0] b);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Latency counts so that a done right after the capture edge reads as 1.
    task automatic wait_done(input int limit, output int lat, output int busy_cycles,
                             output bit timed_out);
        lat         = 0;
        busy_cycles = 0;
        timed_out   = 1'b1;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                lat       = c + 1;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        A     = 40'd0;
        B     = 8'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({Q, R, busy, done, div_zero, ovf} !== 44'd0) begin
            errors++;
            $display("FAIL reset_outputs: got Q=%0h R=%0h busy=%0b done=%0b dz=%0b ovf=%0b required all 0",
                     Q, R, busy, done, div_zero, ovf);
        end
        rst_n = 1'b1;
        $display("reset released, outputs Q=%0h R=%0h", Q, R);
    endtask

    task automatic test_vectors;
        logic [39:0] va [0:7];
        logic [7:0]  vb [0:7];
        logic [31:0] vq [0:7];
        logic [7:0]  vr [0:7];
        logic [39:0] recon;
        int lat, bc;
        bit to;
        va = '{40'd1000, 40'hFE_FFFF_FFFF, 40'd0, 40'd100, 40'h00_FFFF_FFFF,
               40'h04_0000_0003, 40'd12345, 40'h06_FFFF_FFFF};
        vb = '{8'd7, 8'hFF, 8'd5, 8'd10, 8'd1, 8'd8, 8'd255, 8'd7};
        vq = '{32'd142, 32'hFFFF_FFFF, 32'd0, 32'd10, 32'hFFFF_FFFF,
               32'h8000_0000, 32'd48, 32'hFFFF_FFFF};
        vr = '{8'd6, 8'hFE, 8'd0, 8'd0, 8'd0, 8'd3, 8'd105, 8'd6};
        for (int i = 0; i < 8; i++) begin
            capture(va[i], vb[i]);
            wait_done(60, lat, bc, to);
            $display("div A=%0h B=%0h -> Q=%0h R=%0h dz=%0b ovf=%0b lat=%0d busy=%0d",
                     va[i], vb[i], Q, R, div_zero, ovf, lat, bc);
            checks++;
            if (to || lat != 33) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d (timeout=%0b) required 33", i, lat, to);
            end
            checks++;
            if (Q !== vq[i]) begin
                errors++;
                $display("FAIL vec%0d_Q: got %0h required %0h", i, Q, vq[i]);
            end
            checks++;
            if (R !== vr[i]) begin
                errors++;
                $display("FAIL vec%0d_R: got %0h required %0h", i, R, vr[i]);
            end
            checks++;
            if ({div_zero, ovf} !== 2'b00) begin
                errors++;
                $display("FAIL vec%0d_flags: got dz=%0b ovf=%0b required 0 0", i, div_zero, ovf);
            end
            checks++;
            if (bc != 32) begin
                errors++;
                $display("FAIL vec%0d_busy_cycles: got %0d required 32", i, bc);
            end
            recon = 40'(Q) * 40'(vb[i]) + 40'(R);
            checks++;
            if (recon !== va[i] || R >= vb[i]) begin
                errors++;
                $display("FAIL vec%0d_identity: got Q*B+R=%0h R=%0h required %0h with R<%0h",
                         i, recon, R, va[i], vb[i]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_done_width: got done=%0b one cycle later required 0", i, done);
            end
        end
    endtask

    task automatic test_div_zero;
        int lat, bc;
        bit to;
        capture(40'h12_3456_789A, 8'd0);
        wait_done(60, lat, bc, to);
        $display("div A=123456789a B=0 -> Q=%0h R=%0h dz=%0b ovf=%0b lat=%0d", Q, R, div_zero, ovf, lat);
        checks++;
        if (to || lat != 1) begin
            errors++;
            $display("FAIL dz_latency: got %0d (timeout=%0b) required 1", lat, to);
        end
        checks++;
        if ({div_zero, ovf} !== 2'b10) begin
            errors++;
            $display("FAIL dz_flags: got dz=%0b ovf=%0b required 1 0", div_zero, ovf);
        end
        checks++;
        if (Q !== 32'hFFFF_FFFF || R !== 8'hFF) begin
            errors++;
            $display("FAIL dz_result: got Q=%0h R=%0h required ffffffff ff", Q, R);
        end
        checks++;
        if (bc != 0) begin
            errors++;
            $display("FAIL dz_busy: got %0d busy cycles required 0", bc);
        end
        // Results must persist while inputs wander and nothing is requested.
        A = 40'd77;
        B = 8'd3;
        repeat (4) @(negedge clk);
        checks++;
        if (Q !== 32'hFFFF_FFFF || R !== 8'hFF || div_zero !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL dz_hold: got Q=%0h R=%0h dz=%0b done=%0b required ffffffff ff 1 0",
                     Q, R, div_zero, done);
        end
    endtask

    task automatic test_ovf;
        logic [39:0] oa [0:1];
        logic [7:0]  ob [0:1];
        int lat, bc;
        bit to;
        oa = '{40'h01_0000_0000, 40'h07_0000_0000};
        ob = '{8'd1, 8'd7};
        for (int i = 0; i < 2; i++) begin
            capture(oa[i], ob[i]);
            wait_done(60, lat, bc, to);
            $display("div A=%0h B=%0h -> Q=%0h R=%0h dz=%0b ovf=%0b lat=%0d",
                     oa[i], ob[i], Q, R, div_zero, ovf, lat);
            checks++;
            if (to || lat != 1) begin
                errors++;
                $display("FAIL ovf%0d_latency: got %0d (timeout=%0b) required 1", i, lat, to);
            end
            checks++;
            if ({div_zero, ovf} !== 2'b01) begin
                errors++;
                $display("FAIL ovf%0d_flags: got dz=%0b ovf=%0b required 0 1", i, div_zero, ovf);
            end
            checks++;
            if (Q !== 32'hFFFF_FFFF || R !== 8'hFF || bc != 0) begin
                errors++;
                $display("FAIL ovf%0d_result: got Q=%0h R=%0h busy=%0d required ffffffff ff 0",
                         i, Q, R, bc);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_ignored;
        int n_done, done_c;
        logic [31:0] q_at;
        logic [7:0]  r_at;
        n_done = 0;
        done_c = -1;
        q_at   = 32'd0;
        r_at   = 8'd0;
        capture(40'd1000, 8'd7);
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (c == 9) begin
                start = 1'b1;
                A     = 40'd5;
                B     = 8'd1;
            end
            if (c == 10) start = 1'b0;
            if (done) begin
                n_done++;
                done_c = c + 1;
                q_at   = Q;
                r_at   = R;
            end
        end
        $display("div A=1000 B=7 with mid-run start -> Q=%0h R=%0h dones=%0d lat=%0d",
                 q_at, r_at, n_done, done_c);
        checks++;
        if (n_done != 1 || done_c != 33) begin
            errors++;
            $display("FAIL ignore_done: got %0d dones at latency %0d required 1 at 33", n_done, done_c);
        end
        checks++;
        if (q_at !== 32'd142 || r_at !== 8'd6) begin
            errors++;
            $display("FAIL ignore_result: got Q=%0d R=%0d required 142 6", q_at, r_at);
        end
    endtask

    task automatic test_back_to_back;
        int d0, d1, n_done;
        logic [31:0] q0, q1;
        logic [7:0]  r0, r1;
        d0 = -1; d1 = -1; n_done = 0;
        q0 = 0; q1 = 0; r0 = 0; r1 = 0;
        @(negedge clk);
        A     = 40'd1000;
        B     = 8'd7;
        start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    d0 = c; q0 = Q; r0 = R;
                    A = 40'd100;
                    B = 8'd10;
                end else if (n_done == 2) begin
                    d1 = c; q1 = Q; r1 = R;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        $display("back-to-back: first Q=%0d R=%0d at %0d, second Q=%0d R=%0d at %0d",
                 q0, r0, d0, q1, r1, d1);
        checks++;
        if (n_done != 2 || d1 - d0 != 34) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d dones spaced %0d required 2 spaced 34",
                     n_done, d1 - d0);
        end
        checks++;
        if (q0 !== 32'd142 || r0 !== 8'd6 || q1 !== 32'd10 || r1 !== 8'd0) begin
            errors++;
            $display("FAIL b2b_results: got %0d/%0d and %0d/%0d required 142/6 and 10/0",
                     q0, r0, q1, r1);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int n_done, lat, bc;
        bit to;
        n_done = 0;
        capture(40'd1000, 8'd7);
        repeat (14) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset asserted mid-run: busy=%0b done=%0b Q=%0h R=%0h", busy, done, Q, R);
        checks++;
        if ({Q, R, busy, done, div_zero, ovf} !== 44'd0) begin
            errors++;
            $display("FAIL abort_async_clear: got Q=%0h R=%0h busy=%0b done=%0b dz=%0b ovf=%0b required all 0",
                     Q, R, busy, done, div_zero, ovf);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        checks++;
        if (n_done != 0 || Q !== 32'd0 || R !== 8'd0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles Q=%0h R=%0h required 0 0 0", n_done, Q, R);
        end
        capture(40'd12345, 8'd255);
        wait_done(60, lat, bc, to);
        $display("div after abort A=12345 B=255 -> Q=%0d R=%0d lat=%0d", Q, R, lat);
        checks++;
        if (to || lat != 33 || Q !== 32'd48 || R !== 8'd105) begin
            errors++;
            $display("FAIL abort_fresh_div: got Q=%0d R=%0d lat=%0d required 48 105 33", Q, R, lat);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_vectors();
        test_div_zero();
        test_ovf();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
